// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit
// Contents: dmctrl_t memory access encodings, lsu_state_t FSM states,
//   access_size() giving the byte count of an access (0 for illegal encodings).
package lsu_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dmctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    function automatic logic [2:0] access_size(dmctrl_t c);
        return (c == DM_B || c == DM_BU) ? 3'd1 :
               (c == DM_H || c == DM_HU) ? 3'd2 :
               (c == DM_W)               ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake between the CPU datapath and the load/store unit
// Signals: req_valid/req_ready/req_we/req_ctrl/req_addr/req_wdata (request),
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err (response).
// Modports: master = CPU datapath, slave = load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_ctrl;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero-extends assembled little-endian load bytes according to the access type
// Ports: raw (assembled bytes, lane 0 = lowest address), ctrl (access type), data (extended result).
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  dmctrl_t     ctrl,
    output logic [31:0] data
);
    assign data = (ctrl == DM_B)  ? {{24{raw[7]}}, raw[7:0]}   :
                  (ctrl == DM_BU) ? {24'h0, raw[7:0]}          :
                  (ctrl == DM_H)  ? {{16{raw[15]}}, raw[15:0]} :
                  (ctrl == DM_HU) ? {16'h0, raw[15:0]}         : raw;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator that splits misaligned accesses into sequential byte beats
// Ports: clk, rst_n (asynchronous, active low); lsu (request/response handshake, slave side);
//   Address/DataWr/DMWr/DMCtrl drive the byte-addressed little-endian memory, DataRd is its
//   combinational read data.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of
//   splitting them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  lsu,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       DataWr,
    output logic              DMWr,
    output logic [2:0]        DMCtrl,
    input  logic [31:0]       DataRd
);
    lsu_state_t        state, state_n;
    logic              we, spl, accept, done, bad, misal, split, err;
    dmctrl_t           ctrl;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata, asm_q, asm_n, ext;
    logic [1:0]        beat, last;
    logic [4:0]        sh;
    logic [2:0]        size;
    logic [ADDR_W:0]   top_byte;

    // One extra address bit so a request that wraps past 2^ADDR_W still lands above MEM_BYTES.
    assign size     = access_size(dmctrl_t'(lsu.req_ctrl));
    assign top_byte = {1'b0, lsu.req_addr} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
    assign bad      = size == 3'd0 || top_byte >= (ADDR_W+1)'(MEM_BYTES);
    assign misal    = (size == 3'd2 && lsu.req_addr[0]) || (size == 3'd4 && lsu.req_addr[1:0] != 2'b00);

`ifdef LSU_MISALIGN_TRAP_EN
    assign split = 1'b0;
    assign err   = bad | misal;
`else
    assign split = misal;
    assign err   = bad;
`endif

    // Split loads deposit DataRd[7:0] into the lane of the current beat; aligned loads take DataRd whole.
    assign sh    = {beat, 3'b000};
    assign asm_n = spl ? (asm_q & ~(32'hFF << sh)) | ({24'h0, DataRd[7:0]} << sh) : DataRd;

    lsu_load_extend u_ext (
        .raw  (asm_n),
        .ctrl (ctrl),
        .data (ext)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n       = state;
        accept        = 1'b0;
        done          = 1'b0;
        lsu.req_ready = state == IDLE;
        lsu.rsp_valid = state == RESP;
        case (state)
            IDLE: if (lsu.req_valid) begin
                accept  = 1'b1;
                state_n = err ? RESP : ACCESS;
            end
            ACCESS: if (beat == last) begin
                done    = 1'b1;
                state_n = RESP;
            end
            RESP: if (lsu.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            we            <= 1'b0;
            spl           <= 1'b0;
            ctrl          <= DM_W;
            addr          <= '0;
            wdata         <= '0;
            asm_q         <= '0;
            beat          <= '0;
            last          <= '0;
            Address       <= '0;
            DataWr        <= '0;
            DMWr          <= 1'b0;
            DMCtrl        <= DM_W;
            lsu.rsp_rdata <= '0;
            lsu.rsp_err   <= 1'b0;
        end else if (accept) begin
            we            <= lsu.req_we;
            spl           <= split;
            ctrl          <= dmctrl_t'(lsu.req_ctrl);
            addr          <= lsu.req_addr;
            wdata         <= lsu.req_wdata;
            asm_q         <= '0;
            beat          <= '0;
            last          <= split ? 2'(size - 3'd1) : 2'd0;
            Address       <= lsu.req_addr;
            DataWr        <= lsu.req_wdata;
            DMWr          <= lsu.req_we & ~err;
            DMCtrl        <= split ? (lsu.req_we ? DM_B : DM_BU) : lsu.req_ctrl;
            lsu.rsp_rdata <= '0;
            lsu.rsp_err   <= err;
        end else if (state == ACCESS) begin
            asm_q <= asm_n;
            if (done) begin
                DMWr          <= 1'b0;
                lsu.rsp_rdata <= we ? '0 : ext;
            end else begin
                beat    <= beat + 2'd1;
                Address <= addr + ADDR_W'(beat + 2'd1);
                DataWr  <= wdata >> {beat + 2'd1, 3'b000};
            end
        end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
    localparam int MEMB = 32;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
        logic        w;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Address, DataWr, DataRd;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [7:0]  mem  [MEMB];
    logic [7:0]  refm [MEMB];
    int          n_assert = 0, n_fail = 0, dmwr_cnt = 0;
    beat_t       beats[$];

    load_store_unit_if #(.ADDR_W(32)) ifc ();

    load_store_unit #(.MEM_BYTES(MEMB), .ADDR_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lsu     (ifc),
        .Address (Address),
        .DataWr  (DataWr),
        .DMWr    (DMWr),
        .DMCtrl  (DMCtrl),
        .DataRd  (DataRd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bget(logic [31:0] a, int i);
        logic [32:0] ea;
        ea = {1'b0, a} + 33'(i);
        return (ea < 33'(MEMB)) ? mem[ea[4:0]] : 8'h00;
    endfunction

    // Memory returns data already extended per its DMCtrl, like a real data memory.
    always_comb begin
        DataRd = {bget(Address, 3), bget(Address, 2), bget(Address, 1), bget(Address, 0)};
        case (DMCtrl)
            3'b000:  DataRd = {{24{DataRd[7]}}, DataRd[7:0]};
            3'b100:  DataRd = {24'h0, DataRd[7:0]};
            3'b001:  DataRd = {{16{DataRd[15]}}, DataRd[15:0]};
            3'b101:  DataRd = {16'h0, DataRd[15:0]};
            default: DataRd = DataRd;
        endcase
    end

    always @(posedge clk) if (DMWr) begin
        dmwr_cnt <= dmwr_cnt + 1;
        for (int i = 0; i < ((DMCtrl[1:0] == 2'b00) ? 1 : (DMCtrl[1:0] == 2'b01) ? 2 : 4); i++)
            if ({1'b0, Address} + 33'(i) < 33'(MEMB)) mem[5'(Address + 32'(i))] <= DataWr[8*i +: 8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                          input int hold, output logic [31:0] rd, output logic er, output int lat, output int nwr);
        int dm0;
        beats.delete();
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_we    = w;
        ifc.req_ctrl  = c;
        ifc.req_addr  = a;
        ifc.req_wdata = d;
        dm0 = dmwr_cnt;
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        ifc.req_we    = 1'($urandom);
        ifc.req_ctrl  = 3'($urandom);
        ifc.req_addr  = $urandom;
        ifc.req_wdata = $urandom;
        lat = 1;
        while (!ifc.rsp_valid && lat < 20) begin
            beats.push_back('{a: Address, d: DataWr, c: DMCtrl, w: DMWr});
            @(posedge clk);
            #1;
            lat++;
        end
        check("rsp_valid_seen", ifc.rsp_valid, 1);
        rd = ifc.rsp_rdata;
        er = ifc.rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("bp_valid", ifc.rsp_valid, 1);
            check("bp_rdata", ifc.rsp_rdata, rd);
            check("bp_err", ifc.rsp_err, er);
            check("bp_req_ready", ifc.req_ready, 0);
        end
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.rsp_ready = 1'b0;
        check("req_ready_after", ifc.req_ready, 1);
        nwr = dmwr_cnt - dm0;
    endtask

    task automatic verify(input logic w, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
        int          sz, lat, nb, nwr;
        logic        er, mis, xerr;
        logic [31:0] xr;
        logic [63:0] top;
        sz   = (c == 3'd0 || c == 3'd4) ? 1 : (c == 3'd1 || c == 3'd5) ? 2 : (c == 3'd2) ? 4 : 0;
        mis  = sz > 1 && (a % sz) != 0;
        top  = {32'h0, a} + 64'(sz) - 64'd1;
        xerr = sz == 0 || top >= 64'(MEMB) || (TRAP && mis);
        nb   = xerr ? 0 : (mis ? sz : 1);
        xr   = '0;
        if (!xerr && !w) begin
            for (int i = 0; i < sz; i++) xr = xr | (32'(refm[5'(a + 32'(i))]) << (8 * i));
            if (c == 3'd0 && xr[7])  xr = xr | 32'hFFFF_FF00;
            if (c == 3'd1 && xr[15]) xr = xr | 32'hFFFF_0000;
        end
        do_req(w, c, a, d, 0, rd, er, lat, nwr);
        check("err", er, xerr);
        check("rdata", rd, xr);
        check("latency", lat, nb + 1);
        check("beat_count", beats.size(), nb);
        check("dmwr_pulses", nwr, w ? nb : 0);
        foreach (beats[k]) begin
            check("beat_addr", beats[k].a, a + 32'(k));
            check("beat_ctrl", beats[k].c, mis ? (w ? 3'b000 : 3'b100) : c);
            check("beat_dmwr", beats[k].w, w);
            if (w) begin
                if (mis) check("beat_wbyte", beats[k].d[7:0], 8'(d >> (8 * k)));
                else     check("beat_wdata", beats[k].d, d);
            end
        end
        if (!xerr && w) for (int i = 0; i < sz; i++) refm[5'(a + 32'(i))] = 8'(d >> (8 * i));
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        er;
        int          lat, nwr, r;
        logic [2:0]  ctab [13];
        ctab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < MEMB; i++) begin
            mem[i]  = 8'h00;
            refm[i] = 8'h00;
        end
        ifc.req_valid = 1'b0;
        ifc.req_we    = 1'b0;
        ifc.req_ctrl  = 3'd0;
        ifc.req_addr  = '0;
        ifc.req_wdata = '0;
        ifc.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", ifc.req_ready, 1);
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_rsp_rdata", ifc.rsp_rdata, 0);
        check("rst_rsp_err", ifc.rsp_err, 0);
        check("rst_address", Address, 0);
        check("rst_datawr", DataWr, 0);
        check("rst_dmwr", DMWr, 0);
        check("rst_dmctrl", DMCtrl, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;

        verify(1'b1, 3'd2, 32'd8, 32'hDEAD_BEEF, rd);
        verify(1'b0, 3'd0, 32'd8, 32'h0, rd);
        check("lb_8", rd, 32'hFFFF_FFEF);
        verify(1'b0, 3'd4, 32'd8, 32'h0, rd);
        check("lbu_8", rd, 32'h0000_00EF);

        verify(1'b1, 3'd1, 32'd5, 32'h0000_A1B2, rd);
        verify(1'b0, 3'd1, 32'd5, 32'h0, rd);
        check("lh_5", rd, TRAP ? 32'h0 : 32'hFFFF_A1B2);
        verify(1'b0, 3'd5, 32'd5, 32'h0, rd);
        check("lhu_5", rd, TRAP ? 32'h0 : 32'h0000_A1B2);

        for (int i = 0; i < 4; i++) verify(1'b1, 3'd0, 32'(3 + i), 32'(8'h11 * (i + 1)), rd);
        verify(1'b0, 3'd2, 32'd3, 32'h0, rd);
        check("lw_3", rd, TRAP ? 32'h0 : 32'h4433_2211);

        verify(1'b1, 3'd2, 32'd30, 32'h1234_5678, rd);
        verify(1'b0, 3'd3, 32'd4, 32'h0, rd);
        check("ctrl011_rdata", rd, 0);
        verify(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0, rd);

        do_req(1'b0, 3'd2, 32'd8, 32'h0, 3, rd, er, lat, nwr);
        check("bp_lw_data", rd, 32'hDEAD_BEEF);
        check("bp_lw_err", er, 0);

`ifndef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_we    = 1'b1;
        ifc.req_ctrl  = 3'd2;
        ifc.req_addr  = 32'd9;
        ifc.req_wdata = 32'h5566_7788;
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_beat2_addr", Address, 32'd11);
        check("rst_beat2_dmwr", DMWr, 1);
        rst_n = 1'b0;
        #1;
        check("abort_dmwr", DMWr, 0);
        check("abort_req_ready", ifc.req_ready, 1);
        check("abort_rsp_valid", ifc.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_byte0", mem[9], 8'h88);
        check("abort_byte1", mem[10], 8'h77);
        check("abort_byte2", mem[11], refm[11]);
        check("abort_byte3", mem[12], refm[12]);
        refm[9]  = 8'h88;
        refm[10] = 8'h77;
`endif

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            a = (r == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 35));
            verify(1'($urandom), ctab[$urandom_range(0, 12)], a, $urandom, rd);
        end

        for (int i = 0; i < MEMB; i++) check("mem_final", mem[i], refm[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts one load/store request from the CPU datapath through a valid/ready handshake.
- Drives the byte-addressed, little-endian data memory's Address/DataWr/DMWr/DMCtrl bus.
- Splits misaligned halfword/word accesses into sequential byte accesses.
- Assembles and sign/zero-extends load data, then returns a response through a valid/ready handshake.

Parameters:
- MEM_BYTES, 32: size of the data memory in bytes. Any access touching byte >= MEM_BYTES is an error.
- ADDR_W, 32: width of request and memory addresses.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low bytes are used.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access was rejected; memory was not touched.
- Address  out  ADDR_W  memory byte address.
- DataWr  out  32  memory write data.
- DMWr  out  1  memory write strobe.
- DMCtrl  out  3  memory access control.
- DataRd  in  32  combinational memory read data.

Behaviour:
- Reset values, asynchronous on rst_n low:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Address = 0, DataWr = 0, DMWr = 0, DMCtrl = 3'b010.
- States:
  - IDLE: req_ready = 1.
  - ACCESS: one memory beat per cycle.
  - RESP: rsp_valid = 1, held stable until rsp_ready.
- IDLE:
  - On req_valid & req_ready, latch the request.
  - Error check: ctrl not in {000, 001, 010, 100, 101}, or addr + size - 1 >= MEM_BYTES. On error, go directly to RESP with rsp_err = 1 and rsp_rdata = 0; no DMWr.
  - Otherwise compute beat count:
    - Aligned access (H with addr[0] = 0, W with addr[1:0] = 0, any B): 1 beat, DMCtrl = req_ctrl.
    - Misaligned access: size beats (2 or 4). Beat DMCtrl = 000 for stores, 100 for loads. Beat Address = addr + beat index, 0 first.
- ACCESS:
  - Memory outputs are registered and valid for the whole beat cycle.
  - DMWr is 1 for exactly one cycle per store beat and 0 on loads.
  - Store beat k: DataWr = req_wdata >> (8*k), low byte significant.
  - Load beat k: DataRd[7:0] is captured into byte lane k of the assembly register at the end of the cycle. Aligned loads capture DataRd whole.
  - After the last beat, go to RESP.
  - Misaligned loads: final extension is applied at the RESP transition. Sign extension for 000/001, zero extension for 100/101.
- Latency from the accept edge to rsp_valid:
  - Aligned access or error: 2 cycles and 1 cycle respectively.
  - Misaligned H: 3 cycles.
  - Misaligned W: 5 cycles.
- RESP:
  - On rsp_ready, go to IDLE.
  - req_ready goes high the next cycle; there is no same-cycle back-to-back accept.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around is always caught by the bounds check, because MEM_BYTES <= 2^ADDR_W.
- Reset mid-ACCESS aborts the access at once: DMWr = 0, and partially written bytes stay written.
- req_valid outside IDLE is ignored.
- Request inputs need not stay stable after the accept cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned H/W requests are errors. They go to RESP with rsp_err = 1, no memory beats, and 1-cycle latency. ACCESS is always 1 beat.
- Undefined: misaligned requests are split as described above.

Decomposition:
- Package lsu_pkg holds:
  - enum dmctrl_t: DM_B = 3'b000, DM_H = 3'b001, DM_W = 3'b010, DM_BU = 3'b100, DM_HU = 3'b101.
  - enum lsu_state_t: IDLE, ACCESS, RESP.
  - Function access_size(dmctrl_t) returning 1/2/4, and 0 for illegal encodings.
- Sub-module lsu_load_extend: combinational. Takes the assembled 32-bit bytes and a dmctrl_t and returns the extended rsp_rdata. Shared by the aligned and split paths.

Test Plan:
- Aligned SW: addr 0x8, wdata 0xDEADBEEF. Expect one DMWr cycle with Address = 8, DMCtrl = 010, DataWr = 0xDEADBEEF; rsp_valid 2 cycles after accept; rsp_err = 0.
- Aligned LB then LBU: addr 0x8 holding 0xEF. LB returns 0xFFFFFFEF; LBU returns 0x000000EF.
- Misaligned SH: addr 0x5, wdata 0x0000A1B2. Expect two byte beats: (Address 5, DataWr[7:0] = 0xB2), then (Address 6, DataWr[7:0] = 0xA1). A following LH from addr 5 returns 0xFFFFA1B2, and LHU returns 0x0000A1B2. Macro defined: rsp_err = 1 and DMWr never asserted.
- Misaligned LW: addr 0x3 with bytes 3..6 = 11 22 33 44. Expect 4 beats with DMCtrl = 100; rsp_rdata = 0x44332211 at 5-cycle latency.
- Errors, none of which asserts DMWr:
  - SW at addr 30 with MEM_BYTES = 32 -> rsp_err = 1.
  - Ctrl 011 -> rsp_err = 1, rsp_rdata = 0.
  - Addr 0xFFFFFFFF with W -> rsp_err = 1.
- Backpressure and reset:
  - Hold rsp_ready = 0 for 3 cycles: rsp_valid/rsp_rdata stay stable and req_ready stays 0.
  - Assert rst_n low during beat 2 of a misaligned SW: DMWr drops immediately, state returns to IDLE, and bytes 0..1 stay written.
